// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register-file write port between the
// single-cycle ALU path (req0) and the long-latency path (req1). It also keeps a
// per-register pending-write scoreboard so decode can stall on RAW hazards.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              regWr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned NREG = 1 << ADDR_W;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_t;

    rr_t             rr_ptr;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            req0_nz;
    logic            req1_nz;
    logic            contend;
    logic            grant0;
    logic            grant1;

    // Arbitration: x0 requests are absorbed immediately and never compete for
    // the port; nothing is accepted while reset is asserted.
    always_comb begin
        req0_nz    = (req0_addr != '0);
        req1_nz    = (req1_addr != '0);
        contend    = req0_valid & req0_nz & req1_valid & req1_nz;
        grant0     = !reset & req0_valid & req0_nz & (!contend | (rr_ptr == RR_REQ0));
        grant1     = !reset & req1_valid & req1_nz & (!contend | (rr_ptr == RR_REQ1));
        req0_ready = grant0 | (!reset & req0_valid & !req0_nz);
        req1_ready = grant1 | (!reset & req1_valid & !req1_nz);
    end

    // Round-robin pointer: flips only when both requesters contend.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= RR_REQ0;
        end else if (contend) begin
            rr_ptr <= (rr_ptr == RR_REQ0) ? RR_REQ1 : RR_REQ0;
        end
    end

    // Registered write stage driving the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWr   <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (grant0) begin
            regWr   <= 1'b1;
            rd_addr <= req0_addr;
            rd_data <= req0_data;
        end else if (grant1) begin
            regWr   <= 1'b1;
            rd_addr <= req1_addr;
            rd_data <= req1_data;
        end else begin
            regWr   <= 1'b0;
        end
    end

    // Scoreboard next state: issue set is applied last so it wins over both the
    // writeback clear and flush; entry 0 is forced clear.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else if (regWr) begin
            busy_next[rd_addr] = 1'b0;
        end
        if (iss_valid) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard queries for decode.
    always_comb begin
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
    end

endmodule
